bus_arbiter: RTL and testbench

Two-master arbiter placed in front of the existing single-master bus. The test-bench/CPU master (M0) and a future DMA master (M1) share one bus request/grant port. Grants are round-robin with hold: the owner keeps the bus while it requests, subject to an optional starvation timeout. The arbiter muxes the owner's request, write, address and data onto the bus and steers read data back to that owner.

---
 rtl/bus_arbiter_pkg.sv | 27 ++
 rtl/bus_arb_mux.sv | 67 ++++++
 rtl/bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the two-master bus arbiter:
//   - arbiter state encoding (IDLE/GNT0/GNT1; 2'b11 is illegal)
//   - default address/data widths of masters and bus
//   - bus address map constants (memory and FactoCore windows)
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

   // Default widths shared by masters and the bus
   localparam int PKG_ADDR_W = 16;
   localparam int PKG_DATA_W = 64;

   // Arbiter state encoding; grants are a direct decode of these codes
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } arb_state_e;

   // Bus address map
   localparam logic [15:0] MEM_BASE = 16'h0000;
   localparam logic [15:0] MEM_LAST = 16'h07FF;
   localparam logic [15:0] FC_BASE  = 16'h7000;
   localparam logic [15:0] FC_LAST  = 16'h71FF;

endpackage

// File: rtl/bus_arb_mux.sv
// -----------------------------------------------------------------------------
// bus_arb_mux
// Purely combinational steering between two masters and the bus, selected by
// the arbiter state register.
// Ports:
//   state            in   current arbiter state (2-bit code)
//   m0_* / m1_*      in   request, write, address, write data of each master
//   b_req/b_wr/...   out  owner's access forwarded to the bus (zero when idle)
//   b_din            in   read data from the bus
//   m0_din/m1_din    out  read data steered to the owner, zero to the other
// -----------------------------------------------------------------------------
module bus_arb_mux
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = PKG_ADDR_W,
   parameter int DATA_W = PKG_DATA_W
) (
   input  logic [1:0]        state,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_dout,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_dout,
   input  logic [DATA_W-1:0] b_din,
   output logic              b_req,
   output logic              b_wr,
   output logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_dout,
   output logic [DATA_W-1:0] m0_din,
   output logic [DATA_W-1:0] m1_din
);

   // Owner selection for the bus side and read-data return path
   always_comb begin
      b_req  = 1'b0;
      b_wr   = 1'b0;
      b_addr = {ADDR_W{1'b0}};
      b_dout = {DATA_W{1'b0}};
      m0_din = {DATA_W{1'b0}};
      m1_din = {DATA_W{1'b0}};
      case (state)
         ST_GNT0: begin
            b_req  = m0_req;
            b_wr   = m0_wr;
            b_addr = m0_addr;
            b_dout = m0_dout;
            m0_din = b_din;
         end
         ST_GNT1: begin
            b_req  = m1_req;
            b_wr   = m1_wr;
            b_addr = m1_addr;
            b_dout = m1_dout;
            m1_din = b_din;
         end
         default: begin
            // IDLE and the illegal code both park the bus at zero
            b_req  = 1'b0;
            b_wr   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master round-robin arbiter with hold in front of a single-master bus.
// The owner keeps the bus while requesting; if the other master waits
// MAX_HOLD cycles the grant is handed over (MAX_HOLD=0 disables this).
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   m0_*/m1_* (req,wr,addr,dout)  master access inputs
//   m0_grant/m1_grant       grant, decoded from the state register
//   m0_din/m1_din           read data returned to the owner
//   b_req/b_wr/b_addr/b_dout  access forwarded to the bus
//   b_din                   read data from the bus
// -----------------------------------------------------------------------------
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W   = PKG_ADDR_W,
   parameter int DATA_W   = PKG_DATA_W,
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_dout,
   output logic              m0_grant,
   output logic [DATA_W-1:0] m0_din,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_dout,
   output logic              m1_grant,
   output logic [DATA_W-1:0] m1_din,
   output logic              b_req,
   output logic              b_wr,
   output logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_dout,
   input  logic [DATA_W-1:0] b_din
);

   // Counter only needs to reach MAX_HOLD-1
   localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : {HOLD_W{1'b0}};

   arb_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              last_q, last_d;     // 1: M1 owned last, 0: M0 owned last
   logic              timeout_s;

   // State, hold counter and last-owner registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= {HOLD_W{1'b0}};
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
      end
   end

   // Next-state, last-owner and hold counter computation
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      hold_cnt_d = {HOLD_W{1'b0}};
      timeout_s  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
      case (state_q)
         ST_IDLE: begin
            if (m0_req && m1_req) begin
               state_d = last_q ? ST_GNT0 : ST_GNT1;
            end else if (m0_req) begin
               state_d = ST_GNT0;
            end else if (m1_req) begin
               state_d = ST_GNT1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GNT0: begin
            if (!m0_req) begin
               // Hand straight to a waiting master, no idle bubble
               state_d = m1_req ? ST_GNT1 : ST_IDLE;
               last_d  = 1'b0;
            end else if (m1_req && timeout_s) begin
               state_d = ST_GNT1;
               last_d  = 1'b0;
            end else if (m1_req) begin
               state_d    = ST_GNT0;
               hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q
                                                     : hold_cnt_q + HOLD_W'(1);
            end else begin
               state_d = ST_GNT0;
            end
         end
         ST_GNT1: begin
            if (!m1_req) begin
               state_d = m0_req ? ST_GNT0 : ST_IDLE;
               last_d  = 1'b1;
            end else if (m0_req && timeout_s) begin
               state_d = ST_GNT0;
               last_d  = 1'b1;
            end else if (m0_req) begin
               state_d    = ST_GNT1;
               hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q
                                                     : hold_cnt_q + HOLD_W'(1);
            end else begin
               state_d = ST_GNT1;
            end
         end
         default: begin
            // Illegal code 2'b11 recovers to IDLE
            state_d = ST_IDLE;
         end
      endcase
   end

   // Grants follow the state register, so reset drops them asynchronously
   assign m0_grant = (state_q == ST_GNT0);
   assign m1_grant = (state_q == ST_GNT1);

   bus_arb_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux (
      .state   (state_q),
      .m0_req  (m0_req),
      .m0_wr   (m0_wr),
      .m0_addr (m0_addr),
      .m0_dout (m0_dout),
      .m1_req  (m1_req),
      .m1_wr   (m1_wr),
      .m1_addr (m1_addr),
      .m1_dout (m1_dout),
      .b_din   (b_din),
      .b_req   (b_req),
      .b_wr    (b_wr),
      .b_addr  (b_addr),
      .b_dout  (b_dout),
      .m0_din  (m0_din),
      .m1_din  (m1_din)
   );

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter. Two instances share the stimulus:
//   dut    : MAX_HOLD=4 (reset, single master, tie-break, timeout, datapath)
//   dut_nl : MAX_HOLD=0 (unlimited hold)
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   logic        clk;
   logic        reset_n;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [15:0] m0_addr, m1_addr;
   logic [63:0] m0_dout, m1_dout, b_din;

   logic        m0_grant, m1_grant, b_req, b_wr;
   logic [15:0] b_addr;
   logic [63:0] b_dout, m0_din, m1_din;

   logic        nl_m0_grant, nl_m1_grant, nl_b_req, nl_b_wr;
   logic [15:0] nl_b_addr;
   logic [63:0] nl_b_dout, nl_m0_din, nl_m1_din;

   int pass_cnt  = 0;
   int total_cnt = 0;

   bus_arbiter #(.ADDR_W(16), .DATA_W(64), .MAX_HOLD(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
      .m0_grant(m0_grant), .m0_din(m0_din),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
      .m1_grant(m1_grant), .m1_din(m1_din),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_dout(b_dout),
      .b_din(b_din)
   );

   bus_arbiter #(.ADDR_W(16), .DATA_W(64), .MAX_HOLD(0)) dut_nl (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
      .m0_grant(nl_m0_grant), .m0_din(nl_m0_din),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
      .m1_grant(nl_m1_grant), .m1_din(nl_m1_din),
      .b_req(nl_b_req), .b_wr(nl_b_wr), .b_addr(nl_b_addr), .b_dout(nl_b_dout),
      .b_din(b_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 16'h0000; m0_dout = 64'h0;
      m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 16'h0000; m1_dout = 64'h0;
      b_din  = 64'h0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      apply_reset();
      total_cnt++; if (m0_grant !== 1'b0 || m1_grant !== 1'b0) $display("FAIL rst_grants got=%b%b exp=00", m0_grant, m1_grant); else pass_cnt++;
      total_cnt++; if (b_req !== 1'b0 || b_addr !== 16'h0 || b_dout !== 64'h0) $display("FAIL rst_bus got req=%b addr=%h exp req=0 addr=0", b_req, b_addr); else pass_cnt++;
      m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0020;
      step();
      total_cnt++; if (m1_grant !== 1'b1 || b_wr !== 1'b1) $display("FAIL rst_pre_gnt1 got grant=%b wr=%b exp 1 1", m1_grant, b_wr); else pass_cnt++;
      // Assert reset between edges: everything must drop without a clock edge
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      total_cnt++; if (m1_grant !== 1'b0) $display("FAIL rst_async_grant got=%b exp=0", m1_grant); else pass_cnt++;
      total_cnt++; if (b_req !== 1'b0 || b_wr !== 1'b0) $display("FAIL rst_async_bus got req=%b wr=%b exp 0 0", b_req, b_wr); else pass_cnt++;
      idle_inputs();
      step();
      reset_n = 1'b1;
      step();
      step();
      total_cnt++; if (m0_grant !== 1'b0 || m1_grant !== 1'b0 || b_req !== 1'b0) $display("FAIL rst_release_idle got=%b%b req=%b exp=00 0", m0_grant, m1_grant, b_req); else pass_cnt++;
   endtask

   task automatic test_single_master();
      apply_reset();
      m0_req = 1'b1; m0_addr = 16'h0010; m0_wr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         total_cnt++; if (m0_grant !== 1'b1 || m1_grant !== 1'b0) $display("FAIL single_grant cyc=%0d got=%b%b exp=01", i, m1_grant, m0_grant); else pass_cnt++;
         total_cnt++; if (b_req !== 1'b1 || b_addr !== 16'h0010) $display("FAIL single_bus cyc=%0d got req=%b addr=%h exp 1 0010", i, b_req, b_addr); else pass_cnt++;
      end
      m0_req = 1'b0;
      step();
      total_cnt++; if (m0_grant !== 1'b0 || b_req !== 1'b0) $display("FAIL single_release got grant=%b req=%b exp 0 0", m0_grant, b_req); else pass_cnt++;
   endtask

   task automatic test_tie_break();
      apply_reset();
      m0_req = 1'b1; m1_req = 1'b1;
      step();
      total_cnt++; if (m0_grant !== 1'b1 || m1_grant !== 1'b0) $display("FAIL tie_first got m0=%b m1=%b exp 1 0", m0_grant, m1_grant); else pass_cnt++;
      m0_req = 1'b0;
      step();
      total_cnt++; if (m1_grant !== 1'b1 || m0_grant !== 1'b0) $display("FAIL tie_handover got m0=%b m1=%b exp 0 1", m0_grant, m1_grant); else pass_cnt++;
      // M1 leaves last -> next tie goes to M0
      m1_req = 1'b0;
      step();
      total_cnt++; if (m0_grant !== 1'b0 || m1_grant !== 1'b0) $display("FAIL tie_idle1 got m0=%b m1=%b exp 0 0", m0_grant, m1_grant); else pass_cnt++;
      m0_req = 1'b1; m1_req = 1'b1;
      step();
      total_cnt++; if (m0_grant !== 1'b1 || m1_grant !== 1'b0) $display("FAIL tie_after_m1 got m0=%b m1=%b exp 1 0", m0_grant, m1_grant); else pass_cnt++;
      // M0 leaves last -> next tie goes to M1
      m0_req = 1'b0; m1_req = 1'b0;
      step();
      total_cnt++; if (m0_grant !== 1'b0 || m1_grant !== 1'b0) $display("FAIL tie_idle2 got m0=%b m1=%b exp 0 0", m0_grant, m1_grant); else pass_cnt++;
      m0_req = 1'b1; m1_req = 1'b1;
      step();
      total_cnt++; if (m1_grant !== 1'b1 || m0_grant !== 1'b0) $display("FAIL tie_after_m0 got m0=%b m1=%b exp 0 1", m0_grant, m1_grant); else pass_cnt++;
      idle_inputs();
      step();
   endtask

   task automatic test_timeout();
      apply_reset();
      m0_req = 1'b1;
      for (int i = 0; i < 10; i++) step();
      total_cnt++; if (m0_grant !== 1'b1) $display("FAIL to_hold_alone got=%b exp=1", m0_grant); else pass_cnt++;
      m1_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++; if (m0_grant !== 1'b1 || m1_grant !== 1'b0) $display("FAIL to_wait cyc=%0d got m0=%b m1=%b exp 1 0", i, m0_grant, m1_grant); else pass_cnt++;
      end
      step();
      total_cnt++; if (m1_grant !== 1'b1 || m0_grant !== 1'b0) $display("FAIL to_forced got m0=%b m1=%b exp 0 1", m0_grant, m1_grant); else pass_cnt++;
      // Same limit applies back the other way with a fresh counter
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++; if (m1_grant !== 1'b1 || m0_grant !== 1'b0) $display("FAIL to_wait_back cyc=%0d got m0=%b m1=%b exp 0 1", i, m0_grant, m1_grant); else pass_cnt++;
      end
      step();
      total_cnt++; if (m0_grant !== 1'b1 || m1_grant !== 1'b0) $display("FAIL to_forced_back got m0=%b m1=%b exp 1 0", m0_grant, m1_grant); else pass_cnt++;
      idle_inputs();
      step();
   endtask

   task automatic test_unlimited();
      logic seen_m1;
      apply_reset();
      seen_m1 = 1'b0;
      m0_req = 1'b1;
      step();
      m1_req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (nl_m1_grant !== 1'b0) seen_m1 = 1'b1;
      end
      total_cnt++; if (seen_m1 !== 1'b0 || nl_m0_grant !== 1'b1) $display("FAIL unl_hold got seen_m1=%b m0=%b exp 0 1", seen_m1, nl_m0_grant); else pass_cnt++;
      m0_req = 1'b0;
      step();
      total_cnt++; if (nl_m1_grant !== 1'b1 || nl_m0_grant !== 1'b0) $display("FAIL unl_release got m0=%b m1=%b exp 0 1", nl_m0_grant, nl_m1_grant); else pass_cnt++;
      idle_inputs();
      step();
   endtask

   task automatic test_datapath();
      apply_reset();
      m0_addr = 16'h0123; m0_dout = 64'h99; m0_wr = 1'b0;
      m1_req = 1'b1; m1_addr = 16'h7000; m1_wr = 1'b1; m1_dout = 64'h5;
      step();
      total_cnt++; if (b_addr !== 16'h7000 || b_wr !== 1'b1 || b_req !== 1'b1) $display("FAIL dp_m1_ctl got addr=%h wr=%b req=%b exp 7000 1 1", b_addr, b_wr, b_req); else pass_cnt++;
      total_cnt++; if (b_dout !== 64'h5) $display("FAIL dp_m1_dout got=%h exp=5", b_dout); else pass_cnt++;
      b_din = 64'hABCD;
      #1;
      total_cnt++; if (m1_din !== 64'hABCD || m0_din !== 64'h0) $display("FAIL dp_m1_din got m1=%h m0=%h exp abcd 0", m1_din, m0_din); else pass_cnt++;
      m1_req = 1'b0; m0_req = 1'b1;
      step();
      total_cnt++; if (b_addr !== 16'h0123 || b_wr !== 1'b0 || b_dout !== 64'h99) $display("FAIL dp_m0_bus got addr=%h wr=%b dout=%h exp 0123 0 99", b_addr, b_wr, b_dout); else pass_cnt++;
      total_cnt++; if (m0_din !== 64'hABCD || m1_din !== 64'h0) $display("FAIL dp_m0_din got m0=%h m1=%h exp abcd 0", m0_din, m1_din); else pass_cnt++;
      m0_req = 1'b0;
      step();
      total_cnt++; if (b_addr !== 16'h0 || b_dout !== 64'h0 || m0_din !== 64'h0) $display("FAIL dp_idle got addr=%h dout=%h din=%h exp 0 0 0", b_addr, b_dout, m0_din); else pass_cnt++;
      idle_inputs();
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single_master();
      test_tie_break();
      test_timeout();
      test_unlimited();
      test_datapath();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
